// File: rtl/scanline_buffer_pkg.sv
// Shared video constants and types for the scanline buffer and timing generator.
package scanline_buffer_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        SWAP = 2'd2
    } state_t;

    localparam int PIX_W       = 12;
    localparam int ADDR_W      = 9;
    localparam int H_TOTAL     = 424;
    localparam int V_TOTAL     = 262;
    localparam int LINE_ACTIVE = 320;

    localparam logic [PIX_W-1:0] PIX_TRANSPARENT = '0;

    // A palette index with a zero low nibble is transparent.
    function automatic logic is_opaque(input logic [3:0] idx);
        return idx != 4'd0;
    endfunction

endpackage

// File: rtl/scanline_buffer_if.sv
// Renderer-side port of the scanline buffer: pixel writes, line handshake.
interface scanline_buffer_if
    import scanline_buffer_pkg::*;
#(
    parameter int DW = PIX_W
);
    logic          wr_req;
    logic [8:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_done;
    logic          line_start;
    logic [8:0]    render_line;

    modport master (
        output wr_req, wr_addr, wr_data, wr_done,
        input  wr_ready, line_start, render_line
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_done,
        output wr_ready, line_start, render_line
    );
endinterface

// File: rtl/scanline_buffer_dpram_line.sv
// One scanline bank: simple dual-port RAM, one write port, registered read.
module dpram_line
    import scanline_buffer_pkg::*;
#(
    parameter int DW = PIX_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Registered read port; output holds while re_i is low.
    always_ff @(posedge clk) begin
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/scanline_buffer.sv
// Double-buffered scanline store: renderer fills one bank while the other is
// displayed and cleared behind the read pointer; banks swap every line.
module scanline_buffer
    import scanline_buffer_pkg::*;
#(
    parameter int DW     = PIX_W,
    parameter int LINE_W = LINE_ACTIVE,
    parameter int H_LAST = H_TOTAL - 1,
    parameter int V_LAST = V_TOTAL - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pixel,
    input  logic [8:0]    hcnt,
    input  logic [8:0]    vcnt,
    input  logic          hblank,
    input  logic          vblank,
    scanline_buffer_if.slave rnd,
    output logic [DW-1:0] pix_data,
    output logic          overrun
);
    state_t     state_q, state_d;
    logic [8:0] clr_cnt_q, clr_cnt_d;
    logic       bank_sel_q, bank_sel_d;
    logic [8:0] render_line_q, render_line_d;
    logic       line_start_q, line_start_d;
    logic       overrun_q, overrun_d;
    logic       done_seen_q, done_seen_d;

    // Deferred clear of the address read on the previous pixel enable.
    logic       clr_pend_q;
    logic [8:0] clr_addr_q;
    logic       clr_bank_q;

    // Display-side attributes registered alongside the RAM read.
    logic       disp_q, blank_q, hge_q;

    logic       rd_en, disp_sel, wr_fire;
    logic [1:0]                we;
    logic [1:0][8:0]           waddr;
    logic [1:0][DW-1:0]        wdata;
    logic [1:0][DW-1:0]        rdata;

    assign rnd.wr_ready    = (state_q == RUN);
    assign rnd.line_start  = line_start_q;
    assign rnd.render_line = render_line_q;
    assign overrun         = overrun_q;

    assign rd_en   = ce_pixel && (state_q != INIT) && !reset;
    // In SWAP the pixel enable already belongs to the new line, so it reads
    // the bank that is about to become the display bank.
    assign disp_sel = (state_q == SWAP) ? ~bank_sel_q : bank_sel_q;
    assign wr_fire  = rnd.wr_req && (state_q == RUN) &&
                      is_opaque(rnd.wr_data[3:0]) && (rnd.wr_addr < 9'(LINE_W));

    // Line FSM: init sweep, run, one-clk swap with overrun bookkeeping.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        bank_sel_d    = bank_sel_q;
        render_line_d = render_line_q;
        line_start_d  = 1'b0;
        overrun_d     = overrun_q;
        done_seen_d   = done_seen_q | rnd.wr_done;
        case (state_q)
            INIT: begin
                clr_cnt_d   = clr_cnt_q + 9'd1;
                done_seen_d = 1'b0;
                if (clr_cnt_q == 9'd511) begin
                    state_d      = RUN;
                    line_start_d = 1'b1;
                end
            end
            RUN: begin
                if (ce_pixel && hcnt == 9'(H_LAST)) state_d = SWAP;
            end
            SWAP: begin
                bank_sel_d    = ~bank_sel_q;
                render_line_d = (vcnt == 9'(V_LAST)) ? 9'd0 : vcnt + 9'd1;
                line_start_d  = 1'b1;
                // A done pulse coinciding with the swap still finishes the line.
                if (!(done_seen_q || rnd.wr_done)) overrun_d = 1'b1;
                done_seen_d   = 1'b0;
                state_d       = RUN;
            end
            default: state_d = INIT;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            clr_cnt_q     <= '0;
            bank_sel_q    <= 1'b0;
            render_line_q <= '0;
            line_start_q  <= 1'b0;
            overrun_q     <= 1'b0;
            done_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            bank_sel_q    <= bank_sel_d;
            render_line_q <= render_line_d;
            line_start_q  <= line_start_d;
            overrun_q     <= overrun_d;
            done_seen_q   <= done_seen_d;
        end
    end

    // Display pipeline: read address/bank and blanking captured per pixel enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_pend_q <= 1'b0;
            clr_addr_q <= '0;
            clr_bank_q <= 1'b0;
            disp_q     <= 1'b0;
            blank_q    <= 1'b1;
            hge_q      <= 1'b0;
        end else begin
            clr_pend_q <= rd_en;
            if (rd_en) begin
                clr_addr_q <= hcnt;
                clr_bank_q <= disp_sel;
                disp_q     <= disp_sel;
                blank_q    <= hblank | vblank;
                hge_q      <= (hcnt >= 9'(LINE_W));
            end
        end
    end

    // Bank write ports: init sweep, then display clear, then renderer writes.
    // Clear and renderer never target the same bank in the same clk.
    always_comb begin
        we    = '0;
        waddr = '0;
        wdata = '0;
        for (int b = 0; b < 2; b++) begin
            if (reset) begin
                we[b] = 1'b0;
            end else if (state_q == INIT) begin
                we[b]    = 1'b1;
                waddr[b] = clr_cnt_q;
            end else if (clr_pend_q && clr_bank_q == 1'(b)) begin
                we[b]    = 1'b1;
                waddr[b] = clr_addr_q;
            end else if (wr_fire && bank_sel_q != 1'(b)) begin
                we[b]    = 1'b1;
                waddr[b] = rnd.wr_addr;
                wdata[b] = rnd.wr_data;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        dpram_line #(.DW(DW), .AW(ADDR_W)) u_ram (
            .clk     (clk),
            .we_i    (we[g]),
            .waddr_i (waddr[g]),
            .wdata_i (wdata[g]),
            .re_i    (rd_en),
            .raddr_i (hcnt),
            .rdata_o (rdata[g])
        );
    end

    assign pix_data = (blank_q || hge_q) ? DW'(PIX_TRANSPARENT) : rdata[disp_q];
endmodule

// File: tb/tb_scanline_buffer.sv
// Directed bench for scanline_buffer: stimulus pushes expected pixels into a
// queue, an independent monitor pops and compares one per pixel enable.
module tb_scanline_buffer;
    import scanline_buffer_pkg::*;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce_pixel = 1'b0;
    logic [8:0]    hcnt = '0;
    logic [8:0]    vcnt = '0;
    logic          hblank = 1'b0;
    logic          vblank = 1'b0;
    logic [DW-1:0] pix_data;
    logic          overrun;

    scanline_buffer_if #(.DW(DW)) rif();

    scanline_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .ce_pixel (ce_pixel),
        .hcnt     (hcnt),
        .vcnt     (vcnt),
        .hblank   (hblank),
        .vblank   (vblank),
        .rnd      (rif),
        .pix_data (pix_data),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int h; int v; int exp; } pexp_t;
    typedef struct { int a; int d; } wr_t;

    pexp_t expq[$];
    wr_t   wq[$];
    int    exp_cur[512];
    int    exp_next[512];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        foreach (exp_cur[i]) begin
            exp_cur[i]  = 0;
            exp_next[i] = 0;
        end
    endtask

    // Pixel monitor: one expected entry per pixel enable, checked 1 clk later.
    initial begin
        bit    c;
        pexp_t p;
        forever begin
            @(posedge clk);
            c = ce_pixel;
            @(negedge clk);
            if (c) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pix underflow: got pixel %0h with no expectation", pix_data);
                end else begin
                    p = expq.pop_front();
                    check($sformatf("pix v=%0d h=%0d", p.v, p.h), 32'(pix_data), p.exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Reset, check reset outputs, then time the 512-clk init sweep.
    task automatic do_reset();
        int hi;
        reset    = 1'b1;
        ce_pixel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset pix_data", 32'(pix_data), 0);
        check("reset line_start", 32'(rif.line_start), 0);
        check("reset wr_ready", 32'(rif.wr_ready), 0);
        check("reset overrun", 32'(overrun), 0);
        check("reset render_line", 32'(rif.render_line), 0);
        @(posedge clk); #1;
        reset       = 1'b0;
        rif.wr_req  = 1'b0;
        rif.wr_done = 1'b0;
        hi = 0;
        repeat (512) begin
            @(negedge clk);
            if (rif.wr_ready) hi++;
            @(posedge clk); #1;
        end
        check("init wr_ready high clks", hi, 0);
        @(negedge clk);
        check("post-init wr_ready", 32'(rif.wr_ready), 1);
        check("post-init line_start", 32'(rif.line_start), 1);
        @(posedge clk); #1;
        wq.delete();
        clear_model();
    endtask

    // One line of pixel enables (every clk). exp_cur is what this line shows;
    // writes issued during it are expected in exp_next.
    task automatic run_line(input int v, input bit first, input bit done0, input bit done400,
                            input bit exp_ovr, input int stop_h);
        int lo;
        int ls_pos;
        bit acc;
        lo     = 0;
        ls_pos = -1;
        for (int h = 0; h < stop_h; h++) begin
            hcnt        = 9'(h);
            vcnt        = 9'(v);
            ce_pixel    = 1'b1;
            hblank      = (h >= 320);
            vblank      = (v >= 240);
            rif.wr_done = (h == 0 && done0) || (h == 400 && done400);
            if (wq.size() > 0) begin
                rif.wr_req  = 1'b1;
                rif.wr_addr = 9'(wq[0].a);
                rif.wr_data = DW'(wq[0].d);
            end else begin
                rif.wr_req = 1'b0;
            end
            expq.push_back('{h: h, v: v, exp: (h < 320 && v < 240) ? exp_cur[h] : 0});
            @(negedge clk);
            acc = rif.wr_req && rif.wr_ready;
            if (!rif.wr_ready) lo++;
            if (rif.line_start) ls_pos = (ls_pos == -1) ? h : -2;
            if (h == 200)
                check($sformatf("render_line v=%0d", v), 32'(rif.render_line),
                      first ? 0 : ((v == 261) ? 0 : v + 1));
            if (h == 300)
                check($sformatf("overrun v=%0d", v), 32'(overrun), 32'(exp_ovr));
            @(posedge clk); #1;
            if (acc) void'(wq.pop_front());
        end
        rif.wr_done = 1'b0;
        if (stop_h == 424) begin
            check($sformatf("wr_ready low clks v=%0d", v), lo, first ? 0 : 1);
            check($sformatf("line_start pos v=%0d", v), ls_pos, first ? -1 : 1);
            check($sformatf("write queue drained v=%0d", v), wq.size(), 0);
            exp_cur = exp_next;
            foreach (exp_next[i]) exp_next[i] = 0;
        end
    endtask

    initial begin
        rif.wr_req  = 1'b0;
        rif.wr_addr = '0;
        rif.wr_data = '0;
        rif.wr_done = 1'b0;
        clear_model();

        do_reset();
        run_line(9, 1, 0, 1, 0, 424);

        // Opaque, transparent, overwrite, out-of-range and last-pixel writes.
        wq.push_back('{a: 5,   d: 'h123});
        wq.push_back('{a: 7,   d: 'h045});
        wq.push_back('{a: 7,   d: 'h120});
        wq.push_back('{a: 330, d: 'h0AB});
        wq.push_back('{a: 3,   d: 'h7F0});
        wq.push_back('{a: 9,   d: 'h011});
        wq.push_back('{a: 9,   d: 'h022});
        wq.push_back('{a: 319, d: 'h00F});
        exp_next[5]   = 'h123;
        exp_next[7]   = 'h045;
        exp_next[9]   = 'h022;
        exp_next[319] = 'h00F;
        run_line(10, 0, 0, 1, 0, 424);
        run_line(11, 0, 0, 1, 0, 424);
        run_line(12, 0, 0, 1, 0, 424);
        run_line(13, 0, 0, 1, 0, 424);

        // Request presented in the swap clk is held and lands in the new bank.
        wq.push_back('{a: 20, d: 'h3A1});
        exp_next[20] = 'h3A1;
        run_line(14, 0, 0, 1, 0, 424);

        // Done in the swap clk counts; a line with no done sets sticky overrun.
        run_line(15, 0, 0, 0, 0, 424);
        run_line(16, 0, 1, 1, 0, 424);
        run_line(17, 0, 0, 0, 0, 424);
        run_line(18, 0, 0, 1, 1, 424);
        run_line(19, 0, 0, 1, 1, 424);

        // Frame wrap of render_line; blanked pixels still get cleared.
        wq.push_back('{a: 50, d: 'h555});
        exp_next[50] = 'h555;
        run_line(260, 0, 0, 1, 1, 424);
        run_line(261, 0, 0, 1, 1, 424);
        run_line(0,   0, 0, 1, 1, 424);
        run_line(1,   0, 0, 1, 1, 424);

        // Reset mid-line with data in both banks and a write in flight.
        wq.push_back('{a: 60, d: 'h777});
        exp_next[60] = 'h777;
        run_line(99, 0, 0, 1, 1, 424);
        wq.push_back('{a: 61, d: 'h666});
        run_line(100, 0, 0, 0, 1, 70);
        rif.wr_req  = 1'b1;
        rif.wr_addr = 9'd62;
        rif.wr_data = 12'h666;
        do_reset();
        run_line(5, 1, 0, 1, 0, 424);
        run_line(6, 0, 0, 1, 0, 424);

        ce_pixel = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pixel queue drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
